mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle control decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the register-file, PC, IR, ALU-operand and memory strobes, and handshakes with a shared instruction/data memory. A watchdog traps hung memory accesses, and an error state traps illegal opcodes.

## Interface
- WAIT_MAX, 15: consecutive not-ready memory cycles before trapping; 0 disables the watchdog.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory access complete this cycle; ignored when mem_req=0.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access.
- mem_sel_data  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs data.
- reg_we  out  1  register-file write.
- reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = r31.
- wb_src  out  2  write-back data: 0 = ALUOut, 1 = memory data, 2 = PC (already advanced).
- alu_src_b  out  2  ALU operand B: 0 = rt data, 1 = sign-extended immediate.
- alu_op  out  4  ALU operation code.
- state  out  3  current state (debug).
- err  out  1  sticky trap flag.

## Operation
- State encoding: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7.
- All outputs are Moore decodes of state plus opcode/func/zero. Every output not named for a state is 0 in that state.
- START: reset state; all outputs 0; always goes to FETCH next cycle.
- FETCH: mem_req=1, mem_sel_data=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then DECODE.
- DECODE:
  - j: pc_we=1, pc_src=2, then FETCH.
  - jal: same as j, plus reg_we=1, reg_dst=2, wb_src=2.
  - jr (opcode 0x00, func 0x08): pc_we=1, pc_src=3, then FETCH.
  - Unknown opcode: ERR.
  - Otherwise: EXEC.
- EXEC:
  - R-type: alu_src_b=0, alu_op=RTYPE, then WB.
  - lw/sw: alu_src_b=1, alu_op=ADD, then MEM.
  - addi/andi/ori/slti: alu_src_b=1, alu_op=ADD/AND/OR/SLT, then WB.
  - beq/bne: alu_op=SUB; pc_src=1; pc_we = beq&zero | bne&!zero; then FETCH.
- MEM: mem_req=1, mem_sel_data=1, mem_we = (opcode==sw).
  - On mem_ready: sw goes to FETCH, lw goes to WB.
- WB: reg_we=1.
  - reg_dst = 1 for R-type, 0 otherwise.
  - wb_src = 1 for lw, 0 otherwise.
  - Then FETCH.
- ERR: err=1, all strobes 0. Exit only by reset.
- Legal opcodes: 0x00, 0x02 j, 0x03 jal, 0x04 beq, 0x05 bne, 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori, 0x23 lw, 0x2B sw.
- Watchdog:
  - wait_cnt is cleared on entry to FETCH or MEM.
  - It increments each cycle mem_req=1 with mem_ready=0.
  - Reaching WAIT_MAX goes to ERR next edge.
  - mem_ready in the same cycle as the limit wins: the access completes.

## Timing
- Reset values: state=START, err=0, wait_cnt=0, all strobes 0, perf counters 0.
- Assertion of rst_n low drops mem_req and all write strobes immediately (asynchronous), including mid-access. The aborted access is not retried; execution restarts from START.
- Zero-wait memory, cycles per instruction: j/jal/jr 2, beq/bne 3, R-type/ALU-immediate 4, sw 4, lw 5.
- Each memory wait cycle adds one cycle.
- mem_req stays high continuously from state entry through the mem_ready cycle.
- It falls the cycle after mem_ready.
- No back-to-back request without an intervening state change.
- pc_we, ir_we and reg_we are single-cycle pulses per instruction.

## Configuration
- MIPS_MC_PERF_EN defined: adds two 32-bit output counters.
  - instr_retired increments on every transition into FETCH from DECODE, EXEC, MEM or WB.
  - stall_cycles increments each mem_req=1 & mem_ready=0 cycle.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither the counters nor their ports exist.
- Undefined: sequencing is unchanged.

## Structure
- Package mips_ctrl_pkg holds:
  - state encoding;
  - opcode and func constants;
  - alu_op codes: ADD=0, SUB=1, RTYPE=2, AND=3, OR=4, SLT=5;
  - pc_src, reg_dst and wb_src encodings.
- Sub-module mips_mc_decode (combinational): opcode/func to instruction class (rtype, jr, load, store, branch_eq, branch_ne, alu_imm, jump, link, illegal) and immediate alu_op.
- mips_mc_ctrl holds the state register, the watchdog counter and the optional perf counters.

## Test plan
- Reset, then add (op 0x00, func 0x20), mem_ready tied 1 -> states 0,1,2,3,5,1; WB cycle: reg_we=1, reg_dst=1, wb_src=0; single pc_we pulse, in FETCH.
- lw, mem_ready delayed 3 cycles in MEM -> mem_req=1 for 4 MEM cycles, mem_sel_data=1, mem_we=0; then WB with wb_src=1, reg_dst=0; stall_cycles +=3 when MIPS_MC_PERF_EN is defined.
- beq with zero=1, then zero=0; bne with both -> EXEC pc_we=1, pc_src=1 only for beq&1 and bne&0; all four cases return to FETCH.
- jal -> DECODE cycle has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2; next state FETCH.
- WAIT_MAX=4, mem_ready=0 in FETCH -> ERR after 4 request cycles, err=1 sticky; mem_ready=1 exactly on the 4th cycle -> DECODE, err=0.
- Opcode 0x3F -> ERR. rst_n pulsed low mid-MEM (sw) -> mem_req and mem_we fall asynchronously; after release: START, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC  = 2'd2;

  localparam logic [1:0] ALU_B_REG = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;

  // States that own the memory port and restart the watchdog on entry.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/func to instruction class
// flags plus the ALU operation used by immediate arithmetic.
module mips_mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       rtype,
  output logic       jr,
  output logic       load,
  output logic       store,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       alu_imm,
  output logic       jump,
  output logic       link,
  output logic       illegal,
  output logic [3:0] imm_alu_op
);

  always_comb begin
    rtype      = 1'b0;
    jr         = 1'b0;
    load       = 1'b0;
    store      = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    alu_imm    = 1'b0;
    jump       = 1'b0;
    link       = 1'b0;
    illegal    = 1'b0;
    imm_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (func == FUNC_JR) jr = 1'b1;
        else                 rtype = 1'b1;
      end
      OP_J:    jump = 1'b1;
      OP_JAL: begin
        jump = 1'b1;
        link = 1'b1;
      end
      OP_BEQ:  branch_eq = 1'b1;
      OP_BNE:  branch_ne = 1'b1;
      OP_ADDI: alu_imm = 1'b1;
      OP_SLTI: begin
        alu_imm    = 1'b1;
        imm_alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        alu_imm    = 1'b1;
        imm_alu_op = ALU_AND;
      end
      OP_ORI: begin
        alu_imm    = 1'b1;
        imm_alu_op = ALU_OR;
      end
      OP_LW:   load = 1'b1;
      OP_SW:   store = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control sequencer with memory watchdog and illegal-opcode trap.
// Define MIPS_MC_PERF_EN to add the instr_retired / stall_cycles counters.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        err
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
`endif
);

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t         state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg;
  logic           stall, wd_trip;

  logic rtype, jr, load, store, branch_eq, branch_ne, alu_imm, jump, link, illegal;
  logic [3:0] imm_alu_op;

  mips_mc_decode u_decode (
    .opcode     (opcode),
    .func       (func),
    .rtype      (rtype),
    .jr         (jr),
    .load       (load),
    .store      (store),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .alu_imm    (alu_imm),
    .jump       (jump),
    .link       (link),
    .illegal    (illegal),
    .imm_alu_op (imm_alu_op)
  );

  assign stall = mem_req & ~mem_ready;
  // A ready on the limit cycle completes the access instead of trapping.
  assign wd_trip = (WAIT_MAX > 0) && stall && (wait_cnt_reg == WAIT_LAST);
  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_START;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_START:  state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_next = S_DECODE;
        else if (wd_trip) state_next = S_ERR;
      end
      S_DECODE: begin
        if (illegal)          state_next = S_ERR;
        else if (jump || jr)  state_next = S_FETCH;
        else                  state_next = S_EXEC;
      end
      S_EXEC: begin
        if (rtype || alu_imm)     state_next = S_WB;
        else if (load || store)   state_next = S_MEM;
        else                      state_next = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)    state_next = store ? S_FETCH : S_WB;
        else if (wd_trip) state_next = S_ERR;
      end
      S_WB:     state_next = S_FETCH;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_START;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_SEQ;
    reg_we       = 1'b0;
    reg_dst      = REG_DST_RT;
    wb_src       = WB_SRC_ALU;
    alu_src_b    = ALU_B_REG;
    alu_op       = ALU_ADD;
    err          = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (jump || jr) begin
          pc_we  = 1'b1;
          pc_src = jr ? PC_SRC_REG : PC_SRC_JUMP;
        end
        if (link) begin
          reg_we  = 1'b1;
          reg_dst = REG_DST_RA;
          wb_src  = WB_SRC_PC;
        end
      end
      S_EXEC: begin
        if (rtype) begin
          alu_op = ALU_RTYPE;
        end else if (load || store) begin
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_ADD;
        end else if (alu_imm) begin
          alu_src_b = ALU_B_IMM;
          alu_op    = imm_alu_op;
        end else if (branch_eq || branch_ne) begin
          alu_op = ALU_SUB;
          pc_src = PC_SRC_BRANCH;
          pc_we  = (branch_eq & zero) | (branch_ne & ~zero);
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = store;
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = rtype ? REG_DST_RD : REG_DST_RT;
        wb_src  = load ? WB_SRC_MEM : WB_SRC_ALU;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if ((state_next != state_reg) && is_mem_state(state_next)) begin
      wait_cnt_reg <= '0;
    end else if (stall && (WAIT_MAX > 0)) begin
      wait_cnt_reg <= wait_cnt_reg + WCW'(1);
    end
  end

`ifdef MIPS_MC_PERF_EN
  logic [31:0] instr_retired_reg, stall_cycles_reg;
  logic        retire;

  assign retire = (state_next == S_FETCH) &&
                  ((state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                   (state_reg == S_MEM)    || (state_reg == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired_reg <= '0;
      stall_cycles_reg  <= '0;
    end else begin
      if (retire) instr_retired_reg <= instr_retired_reg + 32'd1;
      if (stall)  stall_cycles_reg  <= stall_cycles_reg + 32'd1;
    end
  end

  assign instr_retired = instr_retired_reg;
  assign stall_cycles  = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl (WAIT_MAX=4): stimulus pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_data;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       err;
  } outv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, func;
  logic zero, mem_ready;
  logic mem_req, mem_we, mem_sel_data, ir_we, pc_we, reg_we, err;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] state;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] instr_retired, stall_cycles;
  logic [31:0] ret_snap, stall_snap;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  outv_t exp_q[$];
  string tag_q[$];
  outv_t mon_e, mon_a;
  string mon_t;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .func         (func),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel_data (mem_sel_data),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wb_src       (wb_src),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .state        (state),
    .err          (err)
`ifdef MIPS_MC_PERF_EN
    ,
    .instr_retired(instr_retired),
    .stall_cycles (stall_cycles)
`endif
  );

  // Argument order: state, req, we, sel, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_src, alu_b, alu_op, err
  function automatic outv_t ov(input int st, input int req, input int we, input int sel,
                               input int irw, input int pcw, input int pcs, input int rw,
                               input int rd, input int wbs, input int asb, input int aop,
                               input int e);
    outv_t v;
    v.state = 3'(st);        v.mem_req = 1'(req);   v.mem_we = 1'(we);
    v.mem_sel_data = 1'(sel); v.ir_we = 1'(irw);    v.pc_we = 1'(pcw);
    v.pc_src = 2'(pcs);      v.reg_we = 1'(rw);     v.reg_dst = 2'(rd);
    v.wb_src = 2'(wbs);      v.alu_src_b = 2'(asb); v.alu_op = 4'(aop);
    v.err = 1'(e);
    return v;
  endfunction

  function automatic outv_t x_start(); return ov(0,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic outv_t x_fwait(); return ov(1,1,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic outv_t x_fdone(); return ov(1,1,0,0,1,1,0,0,0,0,0,0,0); endfunction
  function automatic outv_t x_dec();   return ov(2,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic outv_t x_err();   return ov(7,0,0,0,0,0,0,0,0,0,0,0,1); endfunction

  task automatic chk(input string t, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", t, act, req);
    end
  endtask

  task automatic step(input string t, input int op, input int fn, input int z,
                      input int rdy, input outv_t e);
    @(posedge clk);
    #1;
    opcode = 6'(op);
    func = 6'(fn);
    zero = 1'(z);
    mem_ready = 1'(rdy);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic reset_cycle(input string t);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    exp_q.push_back(x_start());
    tag_q.push_back(t);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic txn(input string name);
    $display("txn: %s", name);
  endtask

  // Monitor: one comparison per queued cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_a = {state, mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src,
                 reg_we, reg_dst, wb_src, alu_src_b, alu_op, err};
        n_cmp++;
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL %s: actual=%06h required=%06h (state %0d, required state %0d)",
                   mon_t, mon_a, mon_e, mon_a.state, mon_e.state);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;

    txn("reset");
    reset_cycle("reset");
`ifdef MIPS_MC_PERF_EN
    chk("perf reset instr_retired", instr_retired, 0);
    chk("perf reset stall_cycles", stall_cycles, 0);
`endif

    txn("add");
    step("add fetch",  0, 'h20, 0, 1, x_fdone());
    step("add decode", 0, 'h20, 0, 0, x_dec());
    step("add exec",   0, 'h20, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,0,2,0));
    step("add wb",     0, 'h20, 0, 0, ov(5,0,0,0,0,0,0,1,1,0,0,0,0));

    txn("lw with 3 wait cycles");
    step("lw fetch",  'h23, 0, 0, 1, x_fdone());
`ifdef MIPS_MC_PERF_EN
    ret_snap = instr_retired;
    stall_snap = stall_cycles;
`endif
    step("lw decode", 'h23, 0, 0, 0, x_dec());
    step("lw exec",   'h23, 0, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++)
      step("lw mem wait", 'h23, 0, 0, 0, ov(4,1,0,1,0,0,0,0,0,0,0,0,0));
    step("lw mem ready", 'h23, 0, 0, 1, ov(4,1,0,1,0,0,0,0,0,0,0,0,0));
    step("lw wb",        'h23, 0, 0, 0, ov(5,0,0,0,0,0,0,1,0,1,0,0,0));

    txn("sw");
    step("sw fetch",  'h2B, 0, 0, 1, x_fdone());
`ifdef MIPS_MC_PERF_EN
    chk("perf lw stall delta", stall_cycles - stall_snap, 3);
    chk("perf lw retired delta", instr_retired - ret_snap, 1);
`endif
    step("sw decode", 'h2B, 0, 0, 0, x_dec());
    step("sw exec",   'h2B, 0, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,1,0,0));
    step("sw mem",    'h2B, 0, 0, 1, ov(4,1,1,1,0,0,0,0,0,0,0,0,0));

    txn("ori");
    step("ori fetch",  'h0D, 0, 0, 1, x_fdone());
    step("ori decode", 'h0D, 0, 0, 0, x_dec());
    step("ori exec",   'h0D, 0, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,1,4,0));
    step("ori wb",     'h0D, 0, 0, 0, ov(5,0,0,0,0,0,0,1,0,0,0,0,0));

    txn("slti");
    step("slti fetch",  'h0A, 0, 0, 1, x_fdone());
    step("slti decode", 'h0A, 0, 0, 0, x_dec());
    step("slti exec",   'h0A, 0, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,1,5,0));
    step("slti wb",     'h0A, 0, 0, 0, ov(5,0,0,0,0,0,0,1,0,0,0,0,0));

    txn("beq/bne, zero=1 and zero=0");
    for (int b = 0; b < 4; b++) begin
      int op, z, taken;
      op = (b < 2) ? 'h04 : 'h05;
      z = (b % 2 == 0) ? 1 : 0;
      taken = (b == 0 || b == 3) ? 1 : 0;
      step("branch fetch",  op, 0, 0, 1, x_fdone());
      step("branch decode", op, 0, 0, 0, x_dec());
      step("branch exec",   op, 0, z, 0, ov(3,0,0,0,0,taken,1,0,0,0,0,1,0));
    end

    txn("jal");
    step("jal fetch",  'h03, 0, 0, 1, x_fdone());
    step("jal decode", 'h03, 0, 0, 0, ov(2,0,0,0,0,1,2,1,2,2,0,0,0));
    txn("jr");
    step("jr fetch",  0, 'h08, 0, 1, x_fdone());
    step("jr decode", 0, 'h08, 0, 0, ov(2,0,0,0,0,1,3,0,0,0,0,0,0));
    txn("j");
    step("j fetch",  'h02, 0, 0, 1, x_fdone());
    step("j decode", 'h02, 0, 0, 0, ov(2,0,0,0,0,1,2,0,0,0,0,0,0));

    txn("illegal opcode 0x3F");
    step("ill fetch",  'h3F, 0, 0, 1, x_fdone());
    step("ill decode", 'h3F, 0, 0, 0, x_dec());
    step("ill err",    'h3F, 0, 0, 1, x_err());
    step("ill err sticky", 0, 'h20, 0, 1, x_err());
    reset_cycle("reset after illegal");

    txn("watchdog trap in fetch");
    for (int i = 0; i < 4; i++)
      step("wd fetch wait", 0, 'h20, 0, 0, x_fwait());
    step("wd err", 0, 'h20, 0, 0, x_err());
    step("wd err sticky", 0, 'h20, 0, 1, x_err());
    reset_cycle("reset after watchdog");

    txn("watchdog limit with ready on 4th cycle");
    for (int i = 0; i < 3; i++)
      step("wd2 fetch wait", 0, 'h20, 0, 0, x_fwait());
    step("wd2 fetch ready", 0, 'h20, 0, 1, x_fdone());
    step("wd2 decode",      0, 'h20, 0, 0, x_dec());
    step("wd2 exec",        0, 'h20, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,0,2,0));
    step("wd2 wb",          0, 'h20, 0, 0, ov(5,0,0,0,0,0,0,1,1,0,0,0,0));

    txn("sw aborted by reset mid-MEM");
    step("sw2 fetch",  'h2B, 0, 0, 1, x_fdone());
    step("sw2 decode", 'h2B, 0, 0, 0, x_dec());
    step("sw2 exec",   'h2B, 0, 0, 0, ov(3,0,0,0,0,0,0,0,0,0,1,0,0));
    step("sw2 mem wait", 'h2B, 0, 0, 0, ov(4,1,1,1,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset mem_req", {31'd0, mem_req}, 0);
    chk("async reset mem_we", {31'd0, mem_we}, 0);
    chk("async reset state", {29'd0, state}, 0);
    step("reset held start", 'h2B, 0, 0, 0, x_start());
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step("restart fetch",  'h02, 0, 0, 1, x_fdone());
    step("restart decode", 'h02, 0, 0, 0, ov(2,0,0,0,0,1,2,0,0,0,0,0,0));

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
